axi_arbiter_2to1: RTL and testbench
===================================

// Module: axi_arbiter_2to1
// PURPOSE
//   Shares one downstream AXI slave port between two upstream AXI masters (m0, m1).
//   Write path (AW/W/B) and read path (AR/R) are arbitrated independently by round-robin.
//   Each path has at most one burst outstanding, locked to its owner until that burst completes.
//   Sits between master drivers/DUT masters and a single slave model on the VIP fabric.
// PARAMETERS
//   ADDR_W  32  address width
//   DATA_W  32  data width; STRB_W = DATA_W/8
//   ID_W     4  transaction ID width, passed through unchanged
//   LEN_W    4  burst length field width (beats = len+1)
// PORTS  (mX_ = m0_ and m1_, one set each; s_ = downstream slave side)
//   aclk                                     in   1   clock, all logic on posedge
//   aresetn                                  in   1   asynchronous active-low reset
//   mX_awid/awaddr/awlen/awsize/awburst      in   ID_W/ADDR_W/LEN_W/3/2   write address
//   mX_awvalid in 1 | mX_awready out 1                                    AW handshake
//   mX_wid/wdata/wstrb/wlast                 in   ID_W/DATA_W/STRB_W/1    write data
//   mX_wvalid in 1 | mX_wready out 1                                      W handshake
//   mX_bid/bresp out ID_W/2 | mX_bvalid out 1 | mX_bready in 1            write response
//   mX_arid/araddr/arlen/arsize/arburst      in   ID_W/ADDR_W/LEN_W/3/2   read address
//   mX_arvalid in 1 | mX_arready out 1                                    AR handshake
//   mX_rid/rdata/rresp/rlast out ID_W/DATA_W/2/1 | mX_rvalid out 1 | mX_rready in 1
//   s_*  same signal set as one mX_ port, directions inverted
//   wr_grant / rd_grant                      out  1   current owner (0=m0, 1=m1); valid when busy
//   wr_busy / rd_busy                        out  1   path not in IDLE
//   wlast_err                                out  1   1-cycle pulse: wlast not on beat len
// BEHAVIOUR
// - Reset (async, immediate): all valid/ready outputs 0, all s_/mX_ payload outputs 0,
//   FSMs IDLE, both rr pointers = m0, beat counter 0, wlast_err 0, grants 0.
// - Write FSM: W_IDLE -> W_AW -> W_DATA -> W_RESP -> W_IDLE.
//   W_IDLE: if any mX_awvalid, register owner; -> W_AW next cycle (1-cycle arb latency).
//     Both requesting -> owner = rr pointer; one requesting -> that master regardless.
//   W_AW: s_aw* = owner aw* (combinational mux), s_awvalid = owner awvalid,
//     owner awready = s_awready; latch awlen; AW handshake -> W_DATA.
//   W_DATA: s_w* = owner w*, owner wready = s_wready; beat counter +1 per W handshake;
//     W handshake with wlast=1 -> W_RESP, counter cleared. W is never forwarded before AW
//     handshake (data-before-address masters are stalled, legal AXI).
//     wlast_err pulses if wlast=1 with count!=len, or count==len with wlast=0 (FSM still
//     exits only on wlast=1); counter wraps at 2^LEN_W, no saturation.
//   W_RESP: owner b* = s_b*, owner bvalid = s_bvalid, s_bready = owner bready;
//     B handshake -> W_IDLE, rr pointer = other master than the one just served.
// - Read FSM: R_IDLE -> R_AR -> R_DATA -> R_IDLE, same arbitration/pointer rules;
//   R_DATA routes R to owner, exits on R handshake with rlast=1, pointer toggles there.
// - Non-owner: all its ready/valid outputs 0, payload outputs 0. Owner outside the active
//   phase of a channel sees ready/valid 0 on that channel. s_ valids 0 outside W_AW/W_DATA/R_AR.
// - s_bvalid outside W_RESP / s_rvalid outside R_DATA: ignored, s_bready/s_rready = 0.
// - Write and read paths fully concurrent; same master may own both.
// - Handshake paths are combinational mux (no extra latency after grant); only grant is registered.
// - Reset mid-burst aborts; no completion forwarded; downstream slave is reset by the same aresetn.
// TESTING
// 1 m0 write awlen=3, s_ always ready -> s_awvalid 1 cycle after m0_awvalid, 4 W beats, m0 gets
//   B with bid=awid; m1_* valid/ready stay 0; wlast_err never set.
// 2 After reset m0,m1 awvalid same cycle -> m0 served first, m1 AW issued cycle after m0 B
//   handshake; third simultaneous pair -> m0 again (pointer returned to m0).
// 3 m0 write len=7 concurrent with m1 read arlen=2 -> both complete, no cross-routing of W/R.
// 4 m0 awlen=3, wlast on beat 2 -> wlast_err 1 cycle, FSM -> W_RESP, B routed to m0.
// 5 s_wready low 5 cycles mid-burst -> m0_wready low 5 cycles, s_wdata stable = m0_wdata.
// 6 aresetn low during W_DATA beat 1 -> all valids/readies 0 immediately; after release
//   m1-only request granted 2 cycles later (IDLE -> W_AW), pointer m0.

Source files
------------

// File: rtl/axi_arbiter_2to1_if.sv
// AXI bundle shared by the 2:1 arbiter's upstream and downstream ports.
//   master modport : drives AW/W/AR payload+valid, B/R ready (an AXI master)
//   slave  modport : drives AW/W/AR ready, B/R payload+valid (an AXI slave)
interface axi_arbiter_2to1_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 4
);
  localparam int STRB_W = DATA_W / 8;

  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [LEN_W-1:0]  awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid, awready;

  logic [ID_W-1:0]   wid;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast, wvalid, wready;

  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid, bready;

  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [LEN_W-1:0]  arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid, arready;

  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast, rvalid, rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wid, wdata, wstrb, wlast, wvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    output rready,
    input  awready, wready, bid, bresp, bvalid, arready,
    input  rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wid, wdata, wstrb, wlast, wvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    input  rready,
    output awready, wready, bid, bresp, bvalid, arready,
    output rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_arbiter_2to1.sv
// Two-master to one-slave AXI arbiter. Write (AW/W/B) and read (AR/R) paths
// each run their own round-robin FSM with one burst in flight, locked to the
// owner until the burst's final handshake (B for writes, R-last for reads).
// Only the grant is registered; once granted, every channel is a pure mux.
// Ports:
//   aclk, aresetn        clock, async active-low reset
//   m0, m1 (slave mp)    upstream masters
//   s (master mp)        downstream slave
//   wr_grant/rd_grant    current owner per path (0=m0, 1=m1), meaningful when busy
//   wr_busy/rd_busy      path not idle
//   wlast_err            1-cycle pulse the cycle after a W beat whose wlast
//                        disagrees with the latched awlen
module axi_arbiter_2to1 #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 4
) (
  input  logic              aclk,
  input  logic              aresetn,
  axi_arbiter_2to1_if.slave  m0,
  axi_arbiter_2to1_if.slave  m1,
  axi_arbiter_2to1_if.master s,
  output logic              wr_grant,
  output logic              rd_grant,
  output logic              wr_busy,
  output logic              rd_busy,
  output logic              wlast_err
);
  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] W_IDLE = 2'd0, W_AW = 2'd1, W_DATA = 2'd2, W_RESP = 2'd3;
  localparam logic [1:0] R_IDLE = 2'd0, R_AR = 2'd1, R_DATA = 2'd2;

  logic [1:0]       wst_q, wst_d, rst_q, rst_d;
  logic             wown_q, wown_d, wptr_q, wptr_d;
  logic             rown_q, rown_d, rptr_q, rptr_d;
  logic [LEN_W-1:0] wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic             werr_q, werr_d;

  // phase decodes
  logic w_aw, w_dat, w_rsp, r_ar, r_dat;
  assign w_aw  = (wst_q == W_AW);
  assign w_dat = (wst_q == W_DATA);
  assign w_rsp = (wst_q == W_RESP);
  assign r_ar  = (rst_q == R_AR);
  assign r_dat = (rst_q == R_DATA);

  // owner-selected upstream controls
  logic o_awvalid, o_wvalid, o_wlast, o_bready, o_arvalid, o_rready;
  logic [LEN_W-1:0] o_awlen;
  assign o_awvalid = wown_q ? m1.awvalid : m0.awvalid;
  assign o_awlen   = wown_q ? m1.awlen   : m0.awlen;
  assign o_wvalid  = wown_q ? m1.wvalid  : m0.wvalid;
  assign o_wlast   = wown_q ? m1.wlast   : m0.wlast;
  assign o_bready  = wown_q ? m1.bready  : m0.bready;
  assign o_arvalid = rown_q ? m1.arvalid : m0.arvalid;
  assign o_rready  = rown_q ? m1.rready  : m0.rready;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  assign aw_hs = w_aw  & o_awvalid & s.awready;
  assign w_hs  = w_dat & o_wvalid  & s.wready;
  assign b_hs  = w_rsp & s.bvalid  & o_bready;
  assign ar_hs = r_ar  & o_arvalid & s.arready;
  assign r_hs  = r_dat & s.rvalid  & o_rready;

  // ---------------- downstream side ----------------
  assign s.awvalid = w_aw & o_awvalid;
  assign s.awid    = w_aw ? (wown_q ? m1.awid    : m0.awid)    : {ID_W{1'b0}};
  assign s.awaddr  = w_aw ? (wown_q ? m1.awaddr  : m0.awaddr)  : {ADDR_W{1'b0}};
  assign s.awlen   = w_aw ? o_awlen : {LEN_W{1'b0}};
  assign s.awsize  = w_aw ? (wown_q ? m1.awsize  : m0.awsize)  : 3'd0;
  assign s.awburst = w_aw ? (wown_q ? m1.awburst : m0.awburst) : 2'd0;

  assign s.wvalid  = w_dat & o_wvalid;
  assign s.wid     = w_dat ? (wown_q ? m1.wid   : m0.wid)   : {ID_W{1'b0}};
  assign s.wdata   = w_dat ? (wown_q ? m1.wdata : m0.wdata) : {DATA_W{1'b0}};
  assign s.wstrb   = w_dat ? (wown_q ? m1.wstrb : m0.wstrb) : {STRB_W{1'b0}};
  assign s.wlast   = w_dat & o_wlast;

  assign s.bready  = w_rsp & o_bready;

  assign s.arvalid = r_ar & o_arvalid;
  assign s.arid    = r_ar ? (rown_q ? m1.arid    : m0.arid)    : {ID_W{1'b0}};
  assign s.araddr  = r_ar ? (rown_q ? m1.araddr  : m0.araddr)  : {ADDR_W{1'b0}};
  assign s.arlen   = r_ar ? (rown_q ? m1.arlen   : m0.arlen)   : {LEN_W{1'b0}};
  assign s.arsize  = r_ar ? (rown_q ? m1.arsize  : m0.arsize)  : 3'd0;
  assign s.arburst = r_ar ? (rown_q ? m1.arburst : m0.arburst) : 2'd0;

  assign s.rready  = r_dat & o_rready;

  // ---------------- upstream side ----------------
  // Each master sees a channel only while it owns the path and that channel
  // is the active phase; everything else is held at zero.
  logic wb0, wb1, rd0, rd1;
  assign wb0 = w_rsp & ~wown_q;
  assign wb1 = w_rsp &  wown_q;
  assign rd0 = r_dat & ~rown_q;
  assign rd1 = r_dat &  rown_q;

  assign m0.awready = w_aw  & ~wown_q & s.awready;
  assign m1.awready = w_aw  &  wown_q & s.awready;
  assign m0.wready  = w_dat & ~wown_q & s.wready;
  assign m1.wready  = w_dat &  wown_q & s.wready;
  assign m0.bvalid  = wb0 & s.bvalid;
  assign m1.bvalid  = wb1 & s.bvalid;
  assign m0.bid     = wb0 ? s.bid   : {ID_W{1'b0}};
  assign m1.bid     = wb1 ? s.bid   : {ID_W{1'b0}};
  assign m0.bresp   = wb0 ? s.bresp : 2'd0;
  assign m1.bresp   = wb1 ? s.bresp : 2'd0;

  assign m0.arready = r_ar & ~rown_q & s.arready;
  assign m1.arready = r_ar &  rown_q & s.arready;
  assign m0.rvalid  = rd0 & s.rvalid;
  assign m1.rvalid  = rd1 & s.rvalid;
  assign m0.rid     = rd0 ? s.rid   : {ID_W{1'b0}};
  assign m1.rid     = rd1 ? s.rid   : {ID_W{1'b0}};
  assign m0.rdata   = rd0 ? s.rdata : {DATA_W{1'b0}};
  assign m1.rdata   = rd1 ? s.rdata : {DATA_W{1'b0}};
  assign m0.rresp   = rd0 ? s.rresp : 2'd0;
  assign m1.rresp   = rd1 ? s.rresp : 2'd0;
  assign m0.rlast   = rd0 & s.rlast;
  assign m1.rlast   = rd1 & s.rlast;

  // ---------------- write FSM ----------------
  always_comb begin
    wst_d  = wst_q;
    wown_d = wown_q;
    wptr_d = wptr_q;
    wlen_d = wlen_q;
    wcnt_d = wcnt_q;
    werr_d = 1'b0;
    case (wst_q)
      W_IDLE: if (m0.awvalid | m1.awvalid) begin
        // contention goes to the rr pointer, a lone requester wins outright
        wown_d = (m0.awvalid & m1.awvalid) ? wptr_q : m1.awvalid;
        wst_d  = W_AW;
      end
      W_AW: if (aw_hs) begin
        wlen_d = o_awlen;
        wst_d  = W_DATA;
      end
      W_DATA: if (w_hs) begin
        // flag either early wlast or missing wlast on the len beat
        werr_d = o_wlast ^ (wcnt_q == wlen_q);
        if (o_wlast) begin
          wcnt_d = '0;
          wst_d  = W_RESP;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      W_RESP: if (b_hs) begin
        wst_d  = W_IDLE;
        wptr_d = ~wown_q;
      end
      default: wst_d = W_IDLE;
    endcase
  end

  // ---------------- read FSM ----------------
  always_comb begin
    rst_d  = rst_q;
    rown_d = rown_q;
    rptr_d = rptr_q;
    case (rst_q)
      R_IDLE: if (m0.arvalid | m1.arvalid) begin
        rown_d = (m0.arvalid & m1.arvalid) ? rptr_q : m1.arvalid;
        rst_d  = R_AR;
      end
      R_AR: if (ar_hs) rst_d = R_DATA;
      R_DATA: if (r_hs & s.rlast) begin
        rst_d  = R_IDLE;
        rptr_d = ~rown_q;
      end
      default: rst_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wst_q  <= W_IDLE;
      wown_q <= 1'b0;
      wptr_q <= 1'b0;
      wlen_q <= '0;
      wcnt_q <= '0;
      werr_q <= 1'b0;
      rst_q  <= R_IDLE;
      rown_q <= 1'b0;
      rptr_q <= 1'b0;
    end else begin
      wst_q  <= wst_d;
      wown_q <= wown_d;
      wptr_q <= wptr_d;
      wlen_q <= wlen_d;
      wcnt_q <= wcnt_d;
      werr_q <= werr_d;
      rst_q  <= rst_d;
      rown_q <= rown_d;
      rptr_q <= rptr_d;
    end
  end

  assign wr_grant  = wown_q;
  assign rd_grant  = rown_q;
  assign wr_busy   = (wst_q != W_IDLE);
  assign rd_busy   = (rst_q != R_IDLE);
  assign wlast_err = werr_q;
endmodule

// File: tb/tb_axi_arbiter_2to1.sv
// Directed bench for axi_arbiter_2to1: two scripted masters, a responsive
// slave, and a per-cycle transaction-level model of who owns which channel.
module tb_axi_arbiter_2to1;
  localparam int AW = 32, DW = 32, IW = 4, LW = 4, SW = DW / 8;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic wr_grant, rd_grant, wr_busy, rd_busy, wlast_err;

  axi_arbiter_2to1_if #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .LEN_W(LW)) mi[2] ();
  axi_arbiter_2to1_if #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .LEN_W(LW)) si ();

  axi_arbiter_2to1 #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .LEN_W(LW)) dut (
    .aclk(aclk), .aresetn(aresetn), .m0(mi[0]), .m1(mi[1]), .s(si),
    .wr_grant(wr_grant), .rd_grant(rd_grant), .wr_busy(wr_busy),
    .rd_busy(rd_busy), .wlast_err(wlast_err));

  // master-side drives and observations, indexed by master number
  logic          awv[2], wv[2], wlast[2], bready[2], arv[2], rready[2];
  logic [IW-1:0] awid[2], wid[2], arid[2];
  logic [AW-1:0] awaddr[2], araddr[2];
  logic [LW-1:0] awlen[2], arlen[2];
  logic [2:0]    awsize[2], arsize[2];
  logic [1:0]    awburst[2], arburst[2];
  logic [DW-1:0] wdata[2];
  logic [SW-1:0] wstrb[2];
  logic          awrdy[2], wrdy[2], bv[2], arrdy[2], rv[2], rl[2];
  logic [IW-1:0] bid[2], rid[2];
  logic [1:0]    bresp[2], rresp[2];
  logic [DW-1:0] rdata[2];

  for (genvar g = 0; g < 2; g++) begin : g_m
    assign mi[g].awvalid = awv[g];    assign mi[g].awid    = awid[g];
    assign mi[g].awaddr  = awaddr[g]; assign mi[g].awlen   = awlen[g];
    assign mi[g].awsize  = awsize[g]; assign mi[g].awburst = awburst[g];
    assign mi[g].wvalid  = wv[g];     assign mi[g].wid     = wid[g];
    assign mi[g].wdata   = wdata[g];  assign mi[g].wstrb   = wstrb[g];
    assign mi[g].wlast   = wlast[g];  assign mi[g].bready  = bready[g];
    assign mi[g].arvalid = arv[g];    assign mi[g].arid    = arid[g];
    assign mi[g].araddr  = araddr[g]; assign mi[g].arlen   = arlen[g];
    assign mi[g].arsize  = arsize[g]; assign mi[g].arburst = arburst[g];
    assign mi[g].rready  = rready[g];
    assign awrdy[g] = mi[g].awready;  assign wrdy[g]  = mi[g].wready;
    assign bv[g]    = mi[g].bvalid;   assign bid[g]   = mi[g].bid;
    assign bresp[g] = mi[g].bresp;    assign arrdy[g] = mi[g].arready;
    assign rv[g]    = mi[g].rvalid;   assign rid[g]   = mi[g].rid;
    assign rdata[g] = mi[g].rdata;    assign rresp[g] = mi[g].rresp;
    assign rl[g]    = mi[g].rlast;
  end

  // slave-side drives
  logic s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rlast;
  logic [IW-1:0] s_bid, s_rid;
  logic [1:0]    s_bresp, s_rresp;
  logic [DW-1:0] s_rdata;
  assign si.awready = s_awready; assign si.wready = s_wready;
  assign si.bvalid  = s_bvalid;  assign si.bid    = s_bid;
  assign si.bresp   = s_bresp;   assign si.arready = s_arready;
  assign si.rvalid  = s_rvalid;  assign si.rid    = s_rid;
  assign si.rdata   = s_rdata;   assign si.rresp  = s_rresp;
  assign si.rlast   = s_rlast;

  int n_tests = 0, n_fail = 0;
  int wbeats = 0, errs = 0, stall_lo = 0, stall_bad = 0;
  logic wstall = 1'b0;
  logic grants[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic clr_m(input int m);
    awv[m] = 0; awid[m] = '0; awaddr[m] = '0; awlen[m] = '0; awsize[m] = '0; awburst[m] = '0;
    wv[m] = 0; wid[m] = '0; wdata[m] = '0; wstrb[m] = '0; wlast[m] = 0; bready[m] = 0;
    arv[m] = 0; arid[m] = '0; araddr[m] = '0; arlen[m] = '0; arsize[m] = '0; arburst[m] = '0;
    rready[m] = 0;
  endtask

  function automatic logic sig(input int w, input int m);
    case (w)
      0: return awrdy[m];
      1: return wrdy[m];
      2: return bv[m];
      3: return arrdy[m];
      default: return rv[m];
    endcase
  endfunction

  // wait (sampled on negedge) for a master-side handshake; aborts on reset
  task automatic wait_hs(input int w, input int m, output bit ok, output int n);
    ok = 0; n = 0;
    forever begin
      @(negedge aclk); n++;
      if (!aresetn) return;
      if (sig(w, m)) begin ok = 1; return; end
      if (n >= 300) begin
        n_tests++; n_fail++;
        $display("FAIL timeout wait ch=%0d master=%0d", w, m);
        return;
      end
    end
  endtask

  task automatic do_write(input int m, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                          input int len, input int lastbeat, output int lat);
    bit ok; int n;
    @(posedge aclk); #1;
    awv[m] = 1; awid[m] = id; awaddr[m] = addr; awlen[m] = LW'(len);
    awsize[m] = 3'd2; awburst[m] = 2'd1;
    wait_hs(0, m, ok, lat);
    @(posedge aclk); #1;
    awv[m] = 0;
    if (!ok) begin clr_m(m); return; end
    for (int k = 0; k <= lastbeat; k++) begin
      wv[m] = 1; wid[m] = id; wdata[m] = addr + DW'(k); wstrb[m] = '1;
      wlast[m] = (k == lastbeat);
      wait_hs(1, m, ok, n);
      @(posedge aclk); #1;
      if (!ok) begin clr_m(m); return; end
    end
    wv[m] = 0; wlast[m] = 0; bready[m] = 1;
    wait_hs(2, m, ok, n);
    if (ok) chk("bid", 64'(bid[m]), 64'(id));
    @(posedge aclk); #1;
    clr_m(m);
  endtask

  task automatic do_read(input int m, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                         input int len);
    bit ok; int n; int k;
    @(posedge aclk); #1;
    arv[m] = 1; arid[m] = id; araddr[m] = addr; arlen[m] = LW'(len);
    arsize[m] = 3'd2; arburst[m] = 2'd1;
    wait_hs(3, m, ok, n);
    @(posedge aclk); #1;
    arv[m] = 0; rready[m] = 1;
    k = 0;
    while (ok) begin
      wait_hs(4, m, ok, n);
      if (!ok) break;
      chk("rid", 64'(rid[m]), 64'(id));
      chk("rdata", 64'(rdata[m]), 64'(addr + DW'(k)));
      if (rl[m]) begin chk("rbeats", 64'(k), 64'(len)); break; end
      k++;
    end
    @(posedge aclk); #1;
    clr_m(m);
  endtask

  // responsive slave: always ready (W stallable), B after last W, R = addr+beat
  initial begin
    logic [IW-1:0] cap_bid, cap_rid;
    logic [AW-1:0] rbase;
    int rleft, ridx;
    bit do_b, b_hs;
    rleft = 0; ridx = 0; cap_bid = '0; cap_rid = '0; rbase = '0;
    {s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rlast} = '0;
    s_bid = '0; s_rid = '0; s_bresp = '0; s_rresp = '0; s_rdata = '0;
    forever begin
      @(negedge aclk);
      do_b = 0; b_hs = 0;
      if (!aresetn) begin
        rleft = 0; ridx = 0;
      end else begin
        if (si.awvalid && s_awready) cap_bid = si.awid;
        if (si.wvalid && s_wready && si.wlast) do_b = 1;
        b_hs = s_bvalid && si.bready;
        if (si.arvalid && s_arready) begin
          rleft = int'(si.arlen) + 1; ridx = 0; rbase = si.araddr; cap_rid = si.arid;
        end else if (s_rvalid && si.rready) begin
          rleft--; ridx++;
        end
      end
      @(posedge aclk); #1;
      if (!aresetn) begin
        {s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rlast} = '0;
      end else begin
        s_awready = 1; s_arready = 1; s_wready = !wstall;
        if (b_hs) s_bvalid = 0;
        if (do_b) begin s_bvalid = 1; s_bid = cap_bid; s_bresp = 2'b00; end
        s_rvalid = (rleft > 0); s_rlast = (rleft == 1);
        s_rid = (rleft > 0) ? cap_rid : '0;
        s_rdata = (rleft > 0) ? rbase + DW'(ridx) : '0;
        s_rresp = 2'b00;
      end
    end
  end

  // ownership model: per path, who owns it and which channel is live
  // (0 idle/arbitrating, 1 address, 2 data, 3 response)
  initial begin
    int wph, rph;
    logic wo, ro, wptr, rptr, werr, nerr, kb;
    logic [LW-1:0] wlen, wcnt;
    wph = 0; rph = 0; wo = 0; ro = 0; wptr = 0; rptr = 0; werr = 0; wlen = '0; wcnt = '0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        wph = 0; rph = 0; wo = 0; ro = 0; wptr = 0; rptr = 0; werr = 0; wlen = '0; wcnt = '0;
      end
      chk("s_aw", 64'({si.awvalid, si.awid, si.awaddr, si.awlen, si.awsize, si.awburst}),
          (wph == 1) ? 64'({awv[wo], awid[wo], awaddr[wo], awlen[wo], awsize[wo], awburst[wo]}) : 64'd0);
      chk("s_w", 64'({si.wvalid, si.wid, si.wdata, si.wstrb, si.wlast}),
          (wph == 2) ? 64'({wv[wo], wid[wo], wdata[wo], wstrb[wo], wlast[wo]}) : 64'd0);
      chk("s_ar", 64'({si.arvalid, si.arid, si.araddr, si.arlen, si.arsize, si.arburst}),
          (rph == 1) ? 64'({arv[ro], arid[ro], araddr[ro], arlen[ro], arsize[ro], arburst[ro]}) : 64'd0);
      chk("s_rdy", 64'({si.bready, si.rready}),
          64'({wph == 3 && bready[wo], rph == 2 && rready[ro]}));
      for (int k = 0; k < 2; k++) begin
        kb = k[0];
        chk(k == 0 ? "m0_out" : "m1_out",
            64'({awrdy[k], wrdy[k], bv[k], bid[k], bresp[k], arrdy[k], rv[k], rid[k], rdata[k], rresp[k], rl[k]}),
            64'({wph == 1 && wo == kb && s_awready, wph == 2 && wo == kb && s_wready,
                 (wph == 3 && wo == kb) ? {s_bvalid, s_bid, s_bresp} : 7'd0,
                 rph == 1 && ro == kb && s_arready,
                 (rph == 2 && ro == kb) ? {s_rvalid, s_rid, s_rdata, s_rresp, s_rlast} : 40'd0}));
      end
      chk("status", 64'({wr_busy, rd_busy, wlast_err}), 64'({wph != 0, rph != 0, werr}));
      if (wph != 0) chk("wr_grant", 64'(wr_grant), 64'(wo));
      if (rph != 0) chk("rd_grant", 64'(rd_grant), 64'(ro));
      if (aresetn) begin
        nerr = 0;
        case (wph)
          0: if (awv[0] || awv[1]) begin wo = (awv[0] && awv[1]) ? wptr : awv[1]; wph = 1; end
          1: if (awv[wo] && s_awready) begin wlen = awlen[wo]; wph = 2; end
          2: if (wv[wo] && s_wready) begin
               nerr = (wlast[wo] != (wcnt == wlen));
               if (wlast[wo]) begin wcnt = '0; wph = 3; end else wcnt = wcnt + 1'b1;
             end
          default: if (s_bvalid && bready[wo]) begin wph = 0; wptr = !wo; end
        endcase
        werr = nerr;
        case (rph)
          0: if (arv[0] || arv[1]) begin ro = (arv[0] && arv[1]) ? rptr : arv[1]; rph = 1; end
          1: if (arv[ro] && s_arready) rph = 2;
          default: if (s_rvalid && rready[ro] && s_rlast) begin rph = 0; rptr = !ro; end
        endcase
      end
    end
  end

  // event counters for the directed literal checks
  initial forever begin
    @(negedge aclk);
    if (aresetn) begin
      if (si.wvalid && si.wready) wbeats++;
      if (wlast_err) errs++;
      if (si.awvalid && si.awready) grants.push_back(wr_grant);
      if (wr_busy && wv[0] && !wrdy[0]) begin
        stall_lo++;
        if (si.wdata !== wdata[0]) stall_bad++;
      end
    end
  end

  task automatic rst_chk(input string nm);
    chk({nm, "_valids"}, 64'({si.awvalid, si.wvalid, si.bready, si.arvalid, si.rready}), 64'd0);
    chk({nm, "_mrdy"}, 64'({awrdy[0], wrdy[0], bv[0], arrdy[0], rv[0],
                            awrdy[1], wrdy[1], bv[1], arrdy[1], rv[1]}), 64'd0);
    chk({nm, "_stat"}, 64'({wr_grant, rd_grant, wr_busy, rd_busy, wlast_err}), 64'd0);
    chk({nm, "_pay"}, 64'({si.awaddr, si.wdata}), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge aclk); #2 aresetn = 0;
    #1 rst_chk("reset");
    repeat (2) @(posedge aclk);
    #2 aresetn = 1;
  endtask

  task automatic clr_cnt();
    wbeats = 0; errs = 0; stall_lo = 0; stall_bad = 0; grants.delete();
  endtask

  initial begin
    int lat, lat1, n;
    clr_m(0); clr_m(1);
    #1 rst_chk("init");
    repeat (3) @(posedge aclk);
    #2 aresetn = 1;

    // 1: lone m0 write, 4 beats, one-cycle arbitration latency
    clr_cnt();
    do_write(0, 4'h5, 32'h1000, 3, 3, lat);
    chk("t1_aw_lat", 64'(lat), 64'd2);
    chk("t1_beats", 64'(wbeats), 64'd4);
    chk("t1_err", 64'(errs), 64'd0);

    // 2: simultaneous requests after reset: m0, m1, then m0, m1 again
    do_reset(); clr_cnt();
    fork
      do_write(0, 4'h1, 32'h1100, 1, 1, lat);
      do_write(1, 4'h2, 32'h1200, 1, 1, lat1);
    join
    fork
      do_write(0, 4'h3, 32'h1300, 0, 0, lat);
      do_write(1, 4'h4, 32'h1400, 0, 0, lat1);
    join
    chk("t2_ngrants", 64'(grants.size()), 64'd4);
    if (grants.size() == 4)
      chk("t2_order", 64'({grants[0], grants[1], grants[2], grants[3]}), 64'b0101);

    // 3: concurrent m0 write (8 beats) and m1 read (3 beats)
    clr_cnt();
    fork
      do_write(0, 4'h3, 32'h2000, 7, 7, lat);
      do_read(1, 4'h9, 32'h3000, 2);
    join
    chk("t3_beats", 64'(wbeats), 64'd8);

    // 4: early wlast (len 3, last on beat 2) -> one error pulse
    clr_cnt();
    do_write(0, 4'h1, 32'h4000, 3, 2, lat);
    chk("t4_err", 64'(errs), 64'd1);
    chk("t4_beats", 64'(wbeats), 64'd3);

    // 4b: missing wlast on len beat, then late wlast -> two pulses
    clr_cnt();
    do_write(1, 4'h6, 32'h4100, 1, 2, lat);
    chk("t4b_err", 64'(errs), 64'd2);

    // 5: downstream wready held low 5 cycles mid-burst
    clr_cnt();
    fork
      do_write(0, 4'h2, 32'h5000, 7, 7, lat);
      begin
        n = 0;
        while (wbeats < 2 && n < 300) begin @(negedge aclk); n++; end
        wstall = 1;
        repeat (5) @(negedge aclk);
        wstall = 0;
      end
    join
    chk("t5_stall", 64'(stall_lo), 64'd5);
    chk("t5_wdata", 64'(stall_bad), 64'd0);
    chk("t5_beats", 64'(wbeats), 64'd8);

    // 6: reset during W data, then a lone m1 request
    clr_cnt();
    fork
      do_write(0, 4'h4, 32'h6000, 3, 3, lat);
      begin
        n = 0;
        while (wbeats < 1 && n < 300) begin @(negedge aclk); n++; end
        do_reset();
      end
    join
    chk("t6_busy", 64'({wr_busy, rd_busy}), 64'd0);
    clr_cnt();
    do_write(1, 4'h7, 32'h7000, 1, 1, lat);
    chk("t6_lat", 64'(lat), 64'd2);
    chk("t6_grant", 64'(grants.size() == 1 ? grants[0] : 1'bx), 64'd1);
    chk("t6_err", 64'(errs), 64'd0);

    repeat (3) @(posedge aclk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end
endmodule
